// File: rtl/branch_outcome_queue_if.sv
//------------------------------------------------------------------------------
// Module      : branch_outcome_queue_if
// Description : Push/pop/update bundle between predictor, resolver and queue.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface branch_outcome_queue_if #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
);
    logic                       pred_valid;
    logic                       pred_taken;
    logic                       pred_ready;
    logic                       res_valid;
    logic                       res_taken;
    logic                       upd_result;
    logic                       upd_taken;
    logic                       mispredict;
    logic [$clog2(DEPTH):0]     count;
    logic [CNT_W-1:0]           total_cnt;
    logic [CNT_W-1:0]           miss_cnt;
    logic                       err_underflow;

    modport master (
        output pred_valid, pred_taken, res_valid, res_taken,
        input  pred_ready, upd_result, upd_taken, mispredict,
               count, total_cnt, miss_cnt, err_underflow
    );

    modport slave (
        input  pred_valid, pred_taken, res_valid, res_taken,
        output pred_ready, upd_result, upd_taken, mispredict,
               count, total_cnt, miss_cnt, err_underflow
    );
endinterface

`default_nettype wire

// File: rtl/branch_outcome_queue.sv
//------------------------------------------------------------------------------
// Module      : branch_outcome_queue
// Description : In-order prediction tracking FIFO feeding predictor updates.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module branch_outcome_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  wire logic               clk,
    input  wire logic               rst,
    branch_outcome_queue_if.slave   bus
);
    localparam int                  c_addr_w  = $clog2(DEPTH);
    localparam logic [c_addr_w:0]   c_depth   = (c_addr_w+1)'(DEPTH);
    localparam logic [c_addr_w:0]   c_cnt_one = {{c_addr_w{1'b0}}, 1'b1};
    localparam logic [c_addr_w-1:0] c_ptr_one = {{(c_addr_w-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]    c_st_one  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [DEPTH-1:0]    r_mem;
    logic [c_addr_w-1:0] r_wp;
    logic [c_addr_w-1:0] r_rp;
    logic [c_addr_w:0]   r_count;
    logic                r_upd_result;
    logic                r_upd_taken;
    logic                r_mispredict;
    logic [CNT_W-1:0]    r_total_cnt;
    logic [CNT_W-1:0]    r_miss_cnt;
    logic                r_err_underflow;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_miss;

    assign w_full  = (r_count == c_depth);
    assign w_empty = (r_count == '0);
    // Push is gated by the registered full flag only; a same-cycle pop never frees a slot.
    assign w_push  = bus.pred_valid & ~w_full;
    assign w_pop   = bus.res_valid & ~w_empty;
    assign w_miss  = r_mem[r_rp] ^ bus.res_taken;

    // Entries are never cleared; pointers and occupancy alone define validity.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wp] <= bus.pred_taken;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp            <= '0;
            r_rp            <= '0;
            r_count         <= '0;
            r_upd_result    <= 1'b0;
            r_upd_taken     <= 1'b0;
            r_mispredict    <= 1'b0;
            r_total_cnt     <= '0;
            r_miss_cnt      <= '0;
            r_err_underflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + c_ptr_one;
            end
            if (w_pop) begin
                r_rp <= r_rp + c_ptr_one;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_cnt_one;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_cnt_one;
            end

            r_upd_result <= w_pop;
            r_mispredict <= w_pop & w_miss;
            if (w_pop) begin
                r_upd_taken <= bus.res_taken;
                if (r_total_cnt != '1) begin
                    r_total_cnt <= r_total_cnt + c_st_one;
                end
                if (w_miss && (r_miss_cnt != '1)) begin
                    r_miss_cnt <= r_miss_cnt + c_st_one;
                end
            end

            if (bus.res_valid && w_empty) begin
                r_err_underflow <= 1'b1;
            end
        end
    end

    assign bus.pred_ready    = ~w_full;
    assign bus.count         = r_count;
    assign bus.upd_result    = r_upd_result;
    assign bus.upd_taken     = r_upd_taken;
    assign bus.mispredict    = r_mispredict;
    assign bus.total_cnt     = r_total_cnt;
    assign bus.miss_cnt      = r_miss_cnt;
    assign bus.err_underflow = r_err_underflow;
endmodule

`default_nettype wire
